pc_trace_buffer: RTL
====================

Name: pc_trace_buffer

Overview:
Synthesizable, parametrised circular trace buffer that records the core's {flush, next_PC, PC} stream in hardware and stops on a programmable trigger. It replaces per-cycle $display tracing of PC/next_PC with on-chip capture that a bench or debug port reads back after the event. It sits beside the pipeline's fetch stage and observes PC, next_PC and Predict_Flush.

Parameters:
AW, 32, PC width in bits
DEPTH, 16, entries in trace RAM; power of two, >= 2
POST_TRIG, 8, samples stored after the trigger sample; 0 <= POST_TRIG < DEPTH
IW, log2(DEPTH), index width (derived)

Ports:
clk  in  1  clock, all state updates on rising edge
rstn  in  1  asynchronous active-low reset
sample_valid  in  1  a sample is presented this cycle
sample_pc  in  AW  PC of the sample
sample_next_pc  in  AW  next_PC of the sample
sample_flush  in  1  Predict_Flush for the sample
arm  in  1  one-cycle pulse; clears the buffer and starts capture
trig_mode  in  2  0 = free-run (never triggers), 1 = PC match, 2 = flush, 3 = PC match or flush
trig_pc  in  AW  compare value for modes 1 and 3
rd_en  in  1  read request
rd_idx  in  IW  0 = oldest stored entry
rd_data  out  2*AW+1  {flush, next_pc, pc} of the selected entry
rd_valid  out  1  rd_data valid
state  out  2  0 = IDLE, 1 = ARMED, 2 = POST, 3 = DONE
count  out  IW+1  stored entries, saturates at DEPTH
trig_idx  out  IW  index (oldest-relative) of the trigger sample
wrapped  out  1  at least one entry has been overwritten

Behaviour:
- Reset (async, rstn=0): state=IDLE, wr_ptr=0, count=0, trig_idx=0, wrapped=0, rd_data=0, rd_valid=0, post counter=0. RAM contents are not reset.
- IDLE: samples are ignored. arm -> ARMED.
- arm in any state: clears wr_ptr, count, wrapped, trig_idx and the post counter; latches trig_mode and trig_pc; next state ARMED. arm has priority over a sample in the same cycle, so that sample is dropped.
- ARMED: each sample_valid writes the entry at wr_ptr. wr_ptr increments mod DEPTH. count increments until it saturates at DEPTH. If count == DEPTH when a write occurs, wrapped becomes 1.
- Trigger test applies only in ARMED, on a sample that is being written:
  - hit = (mode 1 or 3 and sample_pc == latched trig_pc) or (mode 2 or 3 and sample_flush).
  - On a hit, the triggering sample is stored and its slot is recorded.
  - If POST_TRIG == 0, next state is DONE. Otherwise next state is POST with the post counter loaded to POST_TRIG.
- POST: each sample_valid is stored and decrements the post counter. When a store takes the counter to 0, next state is DONE. Further triggers are ignored.
- DONE: no writes occur, the buffer is frozen, and samples are ignored.
- Oldest slot = (wrapped ? wr_ptr : 0). Physical address = (oldest + rd_idx) mod DEPTH.
- trig_idx = (trigger slot - oldest) mod DEPTH. It is computed combinationally from the stored slot, so it stays correct after later wraps.
- Read:
  - Latency is 1 cycle: rd_en at edge N gives rd_data/rd_valid at edge N+1. rd_valid is a single-cycle pulse per rd_en.
  - If rd_idx >= count, rd_data=0 and rd_valid=1.
  - Reads are legal in every state. In ARMED/POST they return the current contents. A read and a write to the same slot in one cycle returns the old data.
- Free-run mode (0) never leaves ARMED; the buffer holds the last DEPTH samples.
- A sample_valid gap stalls capture; the post counter counts samples, not cycles.

Test Plan:
- Reset mid-POST (rstn low for 1 ns, asynchronous) -> state=0, count=0, wrapped=0, rd_valid=0 immediately, without waiting for a clock edge.
- DEPTH=16, POST_TRIG=8, mode 1, trig_pc=0x40, PCs 0x00,0x04,... one per cycle after arm -> trigger at sample 17. DONE after sample 25; count=16, wrapped=1, trig_idx=7, rd_idx 0 returns pc 0x24, rd_idx 15 returns pc 0x60.
- Mode 2, flush asserted on the 3rd sample, POST_TRIG=8, 11 samples total -> DONE, count=11, wrapped=0, trig_idx=2, entry 2 has flush=1.
- Mode 0 with 40 samples -> state stays 1, count=16, rd_idx 0 = sample 24, rd_idx 15 = sample 39.
- arm asserted with sample_valid in the same cycle while in DONE -> state=1, count=0, the coincident sample is not stored, and the next sample lands at rd_idx 0.
- rd_en with rd_idx=5 while count=3 -> one cycle later rd_valid=1, rd_data=0. Back-to-back rd_en on indices 0,1,2 -> three consecutive rd_valid pulses in order.

Source files
------------

// File: rtl/pc_trace_buffer_if.sv
// Sample/trigger/readback bundle between the fetch-stage observer and the PC trace buffer.
// The master drives samples, arm/trigger setup and read requests; the slave returns status and read data.
interface pc_trace_buffer_if #(
  parameter int AW    = 32,
  parameter int DEPTH = 16
);
  localparam int IW = $clog2(DEPTH);

  logic          sample_valid;
  logic [AW-1:0] sample_pc;
  logic [AW-1:0] sample_next_pc;
  logic          sample_flush;
  logic          arm;
  logic [1:0]    trig_mode;
  logic [AW-1:0] trig_pc;
  logic          rd_en;
  logic [IW-1:0] rd_idx;
  logic [2*AW:0] rd_data;
  logic          rd_valid;
  logic [1:0]    state;
  logic [IW:0]   count;
  logic [IW-1:0] trig_idx;
  logic          wrapped;

  modport master (
    output sample_valid, sample_pc, sample_next_pc, sample_flush,
    output arm, trig_mode, trig_pc, rd_en, rd_idx,
    input  rd_data, rd_valid, state, count, trig_idx, wrapped
  );

  modport slave (
    input  sample_valid, sample_pc, sample_next_pc, sample_flush,
    input  arm, trig_mode, trig_pc, rd_en, rd_idx,
    output rd_data, rd_valid, state, count, trig_idx, wrapped
  );
endinterface

// File: rtl/pc_trace_buffer.sv
// Circular trace buffer of {flush, next_pc, pc}; captures after arm, stops POST_TRIG samples after a trigger.
//   state  | meaning
//   IDLE   | after reset, samples ignored until arm
//   ARMED  | capturing, testing each stored sample for the trigger
//   POST   | trigger seen, storing the remaining post-trigger samples
//   DONE   | buffer frozen for readback
module pc_trace_buffer #(
  parameter int AW        = 32,
  parameter int DEPTH     = 16,
  parameter int POST_TRIG = 8
) (
  input  logic              clk,
  input  logic              rstn,
  pc_trace_buffer_if.slave  bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int DW = 2 * AW + 1;
  localparam logic [IW:0]   DEPTH_C = (IW+1)'(DEPTH);
  localparam logic [IW-1:0] POST_C  = IW'(POST_TRIG);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        st;
  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] trig_slot;
  logic [IW-1:0] post_cnt;
  logic [IW:0]   cnt;
  logic          wrapped_q;
  logic [1:0]    mode_q;
  logic [AW-1:0] tpc_q;
  logic [DW-1:0] rd_data_q;
  logic          rd_valid_q;
  logic [DW-1:0] ram [DEPTH];

  logic          capture;
  logic          hit;
  logic [IW-1:0] oldest;
  logic [IW-1:0] rd_addr;

  // arm wins over a coincident sample, so that sample never reaches the RAM
  always_comb begin
    capture = 1'b0;
    hit     = 1'b0;
    oldest  = '0;
    rd_addr = '0;
    capture = (st == S_ARMED || st == S_POST) && bus.sample_valid && !bus.arm;
    hit     = (mode_q[0] && (bus.sample_pc == tpc_q)) || (mode_q[1] && bus.sample_flush);
    oldest  = wrapped_q ? wr_ptr : '0;
    rd_addr = oldest + bus.rd_idx;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      ram[wr_ptr] <= {bus.sample_flush, bus.sample_next_pc, bus.sample_pc};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st         <= S_IDLE;
      wr_ptr     <= '0;
      trig_slot  <= '0;
      post_cnt   <= '0;
      cnt        <= '0;
      wrapped_q  <= 1'b0;
      mode_q     <= '0;
      tpc_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_data_q <= ({1'b0, bus.rd_idx} >= cnt) ? '0 : ram[rd_addr];
      end

      if (bus.arm) begin
        st        <= S_ARMED;
        wr_ptr    <= '0;
        trig_slot <= '0;
        post_cnt  <= '0;
        cnt       <= '0;
        wrapped_q <= 1'b0;
        mode_q    <= bus.trig_mode;
        tpc_q     <= bus.trig_pc;
      end else if (capture) begin
        wr_ptr <= wr_ptr + IW'(1);
        if (cnt == DEPTH_C) begin
          wrapped_q <= 1'b1;
        end else begin
          cnt <= cnt + (IW+1)'(1);
        end
        case (st)
          S_ARMED: begin
            if (hit) begin
              trig_slot <= wr_ptr;
              if (POST_TRIG == 0) begin
                st <= S_DONE;
              end else begin
                st       <= S_POST;
                post_cnt <= POST_C;
              end
            end
          end
          S_POST: begin
            post_cnt <= post_cnt - IW'(1);
            if (post_cnt == IW'(1)) begin
              st <= S_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Slot-relative trigger position follows the oldest pointer as it moves
  assign bus.trig_idx = trig_slot - oldest;
  assign bus.state    = st;
  assign bus.count    = cnt;
  assign bus.wrapped  = wrapped_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;

endmodule
